stopwatch_counter: RTL and testbench
====================================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter: MAX_MIN, default 59, highest minute value before minutes wrap to 00 (legal range 1..99).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 tick_1hz  input  1  one-clk-wide enable pulse at 1 Hz (run-mode count).
REQ-005 tick_2hz  input  1  one-clk-wide enable pulse at 2 Hz (adjust-mode count, blink).
REQ-006 paused  input  1  pause-state level from the pause toggle stage; 1 = paused.
REQ-007 adj_state  input  2  mode: 00 run, 01 adjust minutes, 10 adjust seconds, 11 hold.
REQ-008 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD digits of MM:SS.
REQ-009 blink  output  1  display-enable for the field under adjustment; 1 = show.
REQ-010 wrap  output  1  one-clk pulse when the time rolls from MAX_MIN:59 to 00:00 in run mode.

Function
REQ-011 All outputs SHALL be registered; a qualifying tick sampled on edge N SHALL be visible on outputs after edge N (latency 1 clk).
REQ-012 Run (00), paused=0: each tick_1hz SHALL increment SS by one; sec_ones 9->0 with carry to sec_tens; SS 59->00 with carry to minutes.
REQ-013 Run, minutes: min_ones 9->0 with carry to min_tens; MM = MAX_MIN with carry SHALL wrap MM to 00 and assert wrap for that one clk.
REQ-014 Run, paused=1: digits SHALL hold; tick_1hz ignored; no wrap.
REQ-015 Adjust minutes (01): each tick_2hz SHALL increment MM by one, MAX_MIN->00, no carry into or out of seconds; SS holds; wrap stays 0.
REQ-016 Adjust seconds (10): each tick_2hz SHALL increment SS by one, 59->00, no carry into minutes; MM holds.
REQ-017 Adjust modes SHALL ignore paused and tick_1hz.
REQ-018 Hold (11): all digits SHALL hold regardless of ticks and paused.
REQ-019 Simultaneous tick_1hz and tick_2hz: only the tick relevant to the current mode SHALL act; at most one increment per clk.
REQ-020 adj_state change takes effect on the same edge it is sampled; no partial carry SHALL be lost or duplicated across a mode change.
REQ-021 Digits SHALL never hold non-BCD values or sec_tens > 5.
REQ-022 In run and hold modes blink SHALL be 1.

Reset
REQ-023 reset=1 on a rising edge SHALL set all digits to 0, wrap=0, blink=1, blink phase cleared; reset has priority over all ticks and modes.
REQ-024 Reset mid-carry (e.g. at 09:59 with tick_1hz present) SHALL yield 00:00 with no wrap pulse.

Configuration
REQ-025 Macro STOPWATCH_BLINK_EN defined: in modes 01/10 blink SHALL toggle on each tick_2hz, starting at 1 on mode entry.
REQ-026 Macro STOPWATCH_BLINK_EN undefined: blink SHALL be constant 1; port remains present.

Structure
REQ-027 Package stopwatch_pkg SHALL hold the adj_state encodings (ADJ_RUN, ADJ_MIN, ADJ_SEC, ADJ_HOLD), the 4-bit BCD digit typedef and the constant SEC_MAX = 59.
REQ-028 One sub-module, bcd_mod_counter (two BCD digits, inc input, programmable max, carry_out), SHALL be instantiated twice, for seconds and for minutes.

Verification
REQ-029 reset, then 60 tick_1hz pulses in run, paused=0 -> 01:00, wrap never asserted.
REQ-030 Preload 59:58 via adjust modes, run, 2 tick_1hz -> 59:59 then 00:00 with wrap high exactly one clk.
REQ-031 At 00:10 set paused=1, 5 tick_1hz -> stays 00:10; paused=0, 1 tick -> 00:11.
REQ-032 adj_state=10 at 00:58, 3 tick_2hz with tick_1hz coincident -> 00:59, 00:00, 00:01; minutes stay 00; blink toggles each tick_2hz (macro on), constant 1 (macro off).
REQ-033 adj_state=11, 10 ticks of each kind -> digits unchanged; then reset with tick_1hz at 09:59 -> 00:00, wrap=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: adjust-mode encodings, BCD digit type, seconds limit.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ADJ_RUN  = 2'b00,
      ADJ_MIN  = 2'b01,
      ADJ_SEC  = 2'b10,
      ADJ_HOLD = 2'b11
   } adj_e;

   typedef logic [3:0] bcd_t;

   localparam int unsigned SEC_MAX = 59;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps after MAX; o_carry_c flags an increment taken at MAX.
module bcd_mod_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX = 59
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_inc,
   output bcd_t o_tens,
   output bcd_t o_ones,
   output logic o_carry_c
);

   localparam bcd_t MAX_TENS = bcd_t'(MAX / 10);
   localparam bcd_t MAX_ONES = bcd_t'(MAX % 10);

   bcd_t r_tens;
   bcd_t r_ones;
   logic w_at_max;

   assign w_at_max  = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
   assign o_carry_c = i_inc && w_at_max;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tens <= 4'd0;
         r_ones <= 4'd0;
      end else if (i_inc) begin
         if (w_at_max) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
         end else if (r_ones == 4'd9) begin
            r_ones <= 4'd0;
            r_tens <= r_tens + 4'd1;
         end else begin
            r_ones <= r_ones + 4'd1;
         end
      end
   end

   assign o_tens = r_tens;
   assign o_ones = r_ones;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with run/adjust/hold modes and a one-clk wrap pulse.
// Define STOPWATCH_BLINK_EN to blink the field under adjustment; otherwise blink stays 1.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       paused,
   input  logic [1:0] adj_state,
   output bcd_t       min_tens,
   output bcd_t       min_ones,
   output bcd_t       sec_tens,
   output bcd_t       sec_ones,
   output logic       blink,
   output logic       wrap
);

   logic w_mode_run;
   logic w_mode_min;
   logic w_mode_sec;
   logic w_run_tick;
   logic w_sec_inc;
   logic w_min_inc;
   logic w_sec_carry;
   logic w_min_carry;
   logic r_wrap;
   logic r_blink;

   assign w_mode_run = (adj_state == ADJ_RUN);
   assign w_mode_min = (adj_state == ADJ_MIN);
   assign w_mode_sec = (adj_state == ADJ_SEC);

   // Only the tick belonging to the current mode can advance a field.
   assign w_run_tick = w_mode_run && !paused && tick_1hz;
   assign w_sec_inc  = w_run_tick || (w_mode_sec && tick_2hz);
   assign w_min_inc  = (w_run_tick && w_sec_carry) || (w_mode_min && tick_2hz);

   bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
      .i_clk     (clk),
      .i_rst     (reset),
      .i_inc     (w_sec_inc),
      .o_tens    (sec_tens),
      .o_ones    (sec_ones),
      .o_carry_c (w_sec_carry)
   );

   bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
      .i_clk     (clk),
      .i_rst     (reset),
      .i_inc     (w_min_inc),
      .o_tens    (min_tens),
      .o_ones    (min_ones),
      .o_carry_c (w_min_carry)
   );

   always_ff @(posedge clk) begin
      if (reset) r_wrap <= 1'b0;
      else       r_wrap <= w_run_tick && w_min_carry;
   end

`ifdef STOPWATCH_BLINK_EN
   logic [1:0] r_prev_mode;

   // Blink restarts shown on entry to an adjust mode, then toggles per 2 Hz tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_blink     <= 1'b1;
         r_prev_mode <= ADJ_RUN;
      end else begin
         r_prev_mode <= adj_state;
         if (!(w_mode_min || w_mode_sec) || (adj_state != r_prev_mode)) r_blink <= 1'b1;
         else if (tick_2hz)                                               r_blink <= ~r_blink;
      end
   end
`else
   always_ff @(posedge clk) begin
      r_blink <= 1'b1;
   end
`endif

   assign wrap  = r_wrap;
   assign blink = r_blink;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: directed scenarios then random stimulus vs a minute/second model.
module tb_stopwatch_counter;
   import stopwatch_pkg::*;

   localparam int unsigned MAX_MIN = 59;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       tick_2hz = 1'b0;
   logic       paused = 1'b0;
   logic [1:0] adj_state = 2'b00;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       blink, wrap;

   always #5 clk = ~clk;

   stopwatch_counter #(.MAX_MIN(MAX_MIN)) dut (
      .clk       (clk),
      .reset     (reset),
      .tick_1hz  (tick_1hz),
      .tick_2hz  (tick_2hz),
      .paused    (paused),
      .adj_state (adj_state),
      .min_tens  (min_tens),
      .min_ones  (min_ones),
      .sec_tens  (sec_tens),
      .sec_ones  (sec_ones),
      .blink     (blink),
      .wrap      (wrap)
   );

   typedef struct {
      int mm;
      int ss;
      bit wr;
      bit bl;
   } exp_t;

   exp_t       q[$];
   int         m_mm = 0;
   int         m_ss = 0;
   bit         m_blink = 1'b1;
   logic [1:0] m_prev = 2'b00;
   int         n_checks = 0;
   int         n_pass = 0;
   bit         stim_done = 1'b0;

   // Drive one cycle of inputs and queue the state the time should show after the edge.
   task automatic step(input bit rst, input bit t1, input bit t2, input bit p, input logic [1:0] mode);
      exp_t e;
      @(negedge clk);
      reset     = rst;
      tick_1hz  = t1;
      tick_2hz  = t2;
      paused    = p;
      adj_state = mode;
      e.wr = 1'b0;
      if (rst) begin
         m_mm = 0; m_ss = 0; m_blink = 1'b1; m_prev = 2'b00;
      end else begin
         if (mode == 2'b00 && t1 && !p) begin
            m_ss = m_ss + 1;
            if (m_ss == 60) begin
               m_ss = 0;
               m_mm = m_mm + 1;
               if (m_mm > int'(MAX_MIN)) begin
                  m_mm = 0;
                  e.wr = 1'b1;
               end
            end
         end else if (mode == 2'b01 && t2) begin
            m_mm = (m_mm == int'(MAX_MIN)) ? 0 : m_mm + 1;
         end else if (mode == 2'b10 && t2) begin
            m_ss = (m_ss + 1) % 60;
         end
`ifdef STOPWATCH_BLINK_EN
         if (!(mode == 2'b01 || mode == 2'b10) || mode != m_prev) m_blink = 1'b1;
         else if (t2) m_blink = ~m_blink;
`else
         m_blink = 1'b1;
`endif
         m_prev = mode;
      end
      e.mm = m_mm;
      e.ss = m_ss;
      e.bl = m_blink;
      q.push_back(e);
   endtask

   task automatic idle(input int n, input logic [1:0] mode);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, mode);
   endtask

   // Monitor: outputs are valid every cycle once a reset has been queued.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (min_tens == 4'(e.mm / 10) && min_ones == 4'(e.mm % 10) &&
                sec_tens == 4'(e.ss / 10) && sec_ones == 4'(e.ss % 10) &&
                wrap == e.wr && blink == e.bl) begin
               n_pass++;
            end else begin
               $display("FAIL state @%0t: got %0d%0d:%0d%0d wrap=%0b blink=%0b, want %02d:%02d wrap=%0b blink=%0b",
                        $time, min_tens, min_ones, sec_tens, sec_ones, wrap, blink, e.mm, e.ss, e.wr, e.bl);
            end
         end
      end
   end

   initial begin : stimulus
      logic [1:0] mode;
      int         budget;

      // Reset, then 60 run seconds reach 01:00 with no wrap.
      step(1'b1, 1'b0, 1'b0, 1'b0, ADJ_RUN);
      step(1'b1, 1'b1, 1'b1, 1'b0, ADJ_RUN);
      for (int i = 0; i < 60; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, ADJ_RUN);
         step(1'b0, 1'b0, 1'b0, 1'b0, ADJ_RUN);
      end

      // Preload 59:58, then run across the wrap.
      step(1'b1, 1'b0, 1'b0, 1'b0, ADJ_RUN);
      idle(1, ADJ_MIN);
      for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b1, 1'b1, ADJ_MIN);
      idle(1, ADJ_SEC);
      for (int i = 0; i < 58; i++) step(1'b0, 1'b1, 1'b1, 1'b0, ADJ_SEC);
      idle(1, ADJ_RUN);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, ADJ_RUN);
         idle(2, ADJ_RUN);
      end

      // Pause at 00:10.
      step(1'b1, 1'b0, 1'b0, 1'b0, ADJ_RUN);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, ADJ_RUN);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, ADJ_RUN);
      step(1'b0, 1'b1, 1'b0, 1'b0, ADJ_RUN);

      // Adjust seconds from 00:58 with coincident 1 Hz ticks.
      step(1'b1, 1'b0, 1'b0, 1'b0, ADJ_RUN);
      idle(1, ADJ_SEC);
      for (int i = 0; i < 58; i++) step(1'b0, 1'b0, 1'b1, 1'b0, ADJ_SEC);
      idle(2, ADJ_SEC);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, ADJ_SEC);
         idle(1, ADJ_SEC);
      end

      // Hold ignores everything; then reset mid-carry at 09:59.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, i[0], ADJ_HOLD);
      step(1'b1, 1'b0, 1'b0, 1'b0, ADJ_RUN);
      idle(1, ADJ_MIN);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 1'b0, ADJ_MIN);
      idle(1, ADJ_SEC);
      for (int i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b1, 1'b0, ADJ_SEC);
      idle(1, ADJ_RUN);
      step(1'b1, 1'b1, 1'b0, 1'b0, ADJ_RUN);
      idle(2, ADJ_RUN);

      // Random traffic with occasional mode changes and resets.
      mode = 2'b00;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(19) == 0) mode = 2'($urandom_range(3));
         step($urandom_range(299) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
              $urandom_range(3) == 0, mode);
      end

      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      #2;
      if (q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expected states left, want 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
